axi_ni_access_sequencer: RTL and testbench
==========================================

# axi_ni_access_sequencer

Address-channel sequencer between the CVA6 AXI4 master port and the system crossbar. It classifies every AR/AW request against the non-idempotent (NI) region rules from the core's memory map. Normal requests pass with zero added latency, up to a per-direction outstanding limit. An NI request first drains all outstanding traffic, then issues alone, and blocks new traffic until it completes, so MMIO side effects are strictly serialized.

## Interface
- AddrWidth, 64, AXI address width.
- MaxOutstanding, 7, per-direction outstanding transaction limit (≥1).
- NrNiRules, 2, number of NI region rules (1..8).
- NiAddrBase, all-zero, packed array of NrNiRules base addresses (AddrWidth each).
- NiLength, all-zero, packed array of NrNiRules lengths; length 0 disables that rule.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- s_ar_valid_i / s_ar_ready_o  in/out  1  upstream read-address handshake.
- s_ar_addr_i  in  AddrWidth  upstream read address.
- m_ar_valid_o / m_ar_ready_i  out/in  1  downstream read-address handshake.
- s_aw_valid_i / s_aw_ready_o  in/out  1  upstream write-address handshake.
- s_aw_addr_i  in  AddrWidth  upstream write address.
- m_aw_valid_o / m_aw_ready_i  out/in  1  downstream write-address handshake.
- r_done_i  in  1  pulse: R beat with RLAST accepted (rvalid & rready & rlast).
- b_done_i  in  1  pulse: B response accepted.
- ni_busy_o  out  1  high in DRAIN, NI_ISSUE and NI_WAIT.
- err_o  out  1  sticky: completion pulse received while that direction's count is 0.

## Operation
- Address buses are forwarded unmodified outside this block; the block gates only valid/ready: m_x_valid_o = s_x_valid_i & grant_x, s_x_ready_o = m_x_ready_i & grant_x.
- Match: addr is NI if base ≤ addr < base+length for any enabled rule. Arithmetic is in AddrWidth+1 bits, so base+length never wraps.
- Counters rd_cnt/wr_cnt, width clog2(MaxOutstanding+1):
  - +1 on a downstream handshake; −1 on r_done_i/b_done_i; simultaneous +1/−1 leaves the count unchanged.
  - A decrement at 0 keeps the count at 0 and sets err_o.
- FSM states: NORMAL, DRAIN, NI_ISSUE, NI_WAIT. Register ni_sel records the NI channel (0=AR, 1=AW).
- NORMAL:
  - grant_x = s_x_valid_i & !ni(x) & (x_cnt < MaxOutstanding), for each channel independently.
  - If any valid head is NI: neither channel is granted that cycle, and the FSM moves to DRAIN.
  - If both heads are NI: ni_sel = rr; rr toggles after each NI issue.
- DRAIN: no grants. When registered rd_cnt==0 and wr_cnt==0, go to NI_ISSUE.
- NI_ISSUE: only channel ni_sel is granted. On its downstream handshake, go to NI_WAIT.
- NI_WAIT: no grants. On the completion pulse of channel ni_sel, go to NORMAL.
- Upstream obeys AXI: valid and addr stay stable until ready, so the NI head seen in DRAIN is the one issued.

## Timing
- Reset values: state NORMAL, counters 0, rr 0 (AR first), ni_sel 0, err_o 0, ni_busy_o 0. All m_*_valid_o and s_*_ready_o are 0 whenever no grant applies.
- Normal pass-through: 0-cycle combinational latency.
- NI detection in NORMAL → DRAIN next cycle.
- DRAIN with counts 0 at entry → NI_ISSUE on the following cycle, giving a minimum of 2 cycles from NI head to grant.
- A completion in the same cycle counts reach 0 is seen one cycle later (registered compare).
- NI_WAIT → NORMAL the cycle after the completion; a new NI head then re-enters DRAIN.
- Reset mid-operation: immediate return to reset values; in-flight downstream transactions are forgotten, and the system resets them together.

## Structure
- Shared package axi_ni_seq_pkg:
  - ni_state_e enum.
  - ni_rule_t struct {base, length}.
  - Function in_region(addr, rule).
- Sub-module ni_region_match (combinational, parameterized over rules), instantiated twice (AR, AW). The FSM and counters live in the top.

## Test plan
- Reset, then 7 AR to 0x8000_0000 with m_ar_ready=1 and no completions → all 7 pass with 0 latency; the 8th is held (s_ar_ready_o=0) until r_done_i, then passes.
- Rule {0x1000_0000, 0x1000}: 2 writes outstanding, AW to 0x1000_0004 → DRAIN until two b_done_i; AW granted 1 cycle after wr_cnt==0; ni_busy_o cleared the cycle after its b_done_i.
- AR NI (0x1000_0000) and AW NI (0x1000_0008) valid together from reset → AR issued first, then AW; a second pair is issued AW first (rr).
- Simultaneous m_ar handshake and r_done_i at rd_cnt=3 → rd_cnt stays 3.
- b_done_i at wr_cnt=0 → err_o=1 and stays 1; wr_cnt remains 0.
- Assert rst_i in NI_WAIT → same cycle state NORMAL, counts 0, ni_busy_o=0, and a normal AR passes immediately after release.

Source files
------------

// File: rtl/axi_ni_seq_pkg.sv
// Shared types and region helper for the AXI non-idempotent access sequencer.
package axi_ni_seq_pkg;

  localparam int unsigned MaxAddrW = 64;

  typedef enum logic [1:0] {
    ST_NORMAL   = 2'd0,
    ST_DRAIN    = 2'd1,
    ST_NI_ISSUE = 2'd2,
    ST_NI_WAIT  = 2'd3
  } ni_state_e;

  typedef struct packed {
    logic [MaxAddrW-1:0] base;
    logic [MaxAddrW-1:0] length;
  } ni_rule_t;

  // One extra bit on the limit so base+length can never wrap around.
  function automatic logic in_region(input logic [MaxAddrW-1:0] addr, input ni_rule_t rule);
    logic [MaxAddrW:0] lim;
    lim = {1'b0, rule.base} + {1'b0, rule.length};
    return (rule.length != '0) && (addr >= rule.base) && ({1'b0, addr} < lim);
  endfunction

endpackage

// File: rtl/ni_region_match.sv
// Combinational check of one address against every non-idempotent region rule.
module ni_region_match
  import axi_ni_seq_pkg::*;
#(
  parameter int unsigned                    AddrWidth  = 64,
  parameter int unsigned                    NrNiRules  = 2,
  parameter logic [NrNiRules*AddrWidth-1:0] NiAddrBase = '0,
  parameter logic [NrNiRules*AddrWidth-1:0] NiLength   = '0
) (
  input  logic [AddrWidth-1:0] addr,
  output logic                 match
);

  logic [MaxAddrW-1:0] addr_ext;
  ni_rule_t            rule;

  always_comb begin
    match    = 1'b0;
    rule     = '0;
    addr_ext = '0;
    addr_ext[AddrWidth-1:0] = addr;
    for (int i = 0; i < NrNiRules; i++) begin
      rule = '0;
      rule.base[AddrWidth-1:0]   = NiAddrBase[i*AddrWidth +: AddrWidth];
      rule.length[AddrWidth-1:0] = NiLength[i*AddrWidth +: AddrWidth];
      match = match | in_region(addr_ext, rule);
    end
  end

endmodule

// File: rtl/axi_ni_access_sequencer.sv
// Gates AR/AW handshakes so non-idempotent accesses issue alone after all
// outstanding traffic drains; normal traffic passes combinationally.
module axi_ni_access_sequencer
  import axi_ni_seq_pkg::*;
#(
  parameter int unsigned                    AddrWidth      = 64,
  parameter int unsigned                    MaxOutstanding = 7,
  parameter int unsigned                    NrNiRules      = 2,
  parameter logic [NrNiRules*AddrWidth-1:0] NiAddrBase     = '0,
  parameter logic [NrNiRules*AddrWidth-1:0] NiLength       = '0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 s_ar_valid_i,
  output logic                 s_ar_ready_o,
  input  logic [AddrWidth-1:0] s_ar_addr_i,
  output logic                 m_ar_valid_o,
  input  logic                 m_ar_ready_i,
  input  logic                 s_aw_valid_i,
  output logic                 s_aw_ready_o,
  input  logic [AddrWidth-1:0] s_aw_addr_i,
  output logic                 m_aw_valid_o,
  input  logic                 m_aw_ready_i,
  input  logic                 r_done_i,
  input  logic                 b_done_i,
  output logic                 ni_busy_o,
  output logic                 err_o
);

  localparam int unsigned     CntW   = $clog2(MaxOutstanding + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(MaxOutstanding);

  ni_state_e       state;
  logic [CntW-1:0] rd_cnt, wr_cnt;
  logic            ni_sel, ni_arb, rr;
  logic            ar_match, aw_match, ar_ni, aw_ni;
  logic            grant_ar, grant_aw, ar_hs, aw_hs;

  ni_region_match #(
    .AddrWidth (AddrWidth),
    .NrNiRules (NrNiRules),
    .NiAddrBase(NiAddrBase),
    .NiLength  (NiLength)
  ) u_ar_match (
    .addr (s_ar_addr_i),
    .match(ar_match)
  );

  ni_region_match #(
    .AddrWidth (AddrWidth),
    .NrNiRules (NrNiRules),
    .NiAddrBase(NiAddrBase),
    .NiLength  (NiLength)
  ) u_aw_match (
    .addr (s_aw_addr_i),
    .match(aw_match)
  );

  assign ar_ni = s_ar_valid_i & ar_match;
  assign aw_ni = s_aw_valid_i & aw_match;

  always_comb begin
    grant_ar = 1'b0;
    grant_aw = 1'b0;
    case (state)
      ST_NORMAL: begin
        if (!(ar_ni || aw_ni)) begin
          grant_ar = s_ar_valid_i && (rd_cnt < CntMax);
          grant_aw = s_aw_valid_i && (wr_cnt < CntMax);
        end
      end
      ST_NI_ISSUE: begin
        grant_ar = s_ar_valid_i & ~ni_sel;
        grant_aw = s_aw_valid_i & ni_sel;
      end
      default: ;
    endcase
  end

  assign m_ar_valid_o = s_ar_valid_i & grant_ar;
  assign s_ar_ready_o = m_ar_ready_i & grant_ar;
  assign m_aw_valid_o = s_aw_valid_i & grant_aw;
  assign s_aw_ready_o = m_aw_ready_i & grant_aw;
  assign ar_hs        = m_ar_valid_o & m_ar_ready_i;
  assign aw_hs        = m_aw_valid_o & m_aw_ready_i;
  assign ni_busy_o    = (state != ST_NORMAL);

  // Outstanding counters; a completion with nothing outstanding is flagged, not counted.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_cnt <= '0;
      wr_cnt <= '0;
      err_o  <= 1'b0;
    end else begin
      if (ar_hs && !r_done_i) begin
        rd_cnt <= rd_cnt + 1'b1;
      end else if (!ar_hs && r_done_i && (rd_cnt != '0)) begin
        rd_cnt <= rd_cnt - 1'b1;
      end
      if (aw_hs && !b_done_i) begin
        wr_cnt <= wr_cnt + 1'b1;
      end else if (!aw_hs && b_done_i && (wr_cnt != '0)) begin
        wr_cnt <= wr_cnt - 1'b1;
      end
      if ((r_done_i && !ar_hs && (rd_cnt == '0)) ||
          (b_done_i && !aw_hs && (wr_cnt == '0))) begin
        err_o <= 1'b1;
      end
    end
  end

  // rr only advances when both channels contended for the NI slot.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= ST_NORMAL;
      ni_sel <= 1'b0;
      ni_arb <= 1'b0;
      rr     <= 1'b0;
    end else begin
      case (state)
        ST_NORMAL: begin
          if (ar_ni || aw_ni) begin
            state  <= ST_DRAIN;
            ni_arb <= ar_ni && aw_ni;
            ni_sel <= (ar_ni && aw_ni) ? rr : aw_ni;
          end
        end
        ST_DRAIN: begin
          if ((rd_cnt == '0) && (wr_cnt == '0)) state <= ST_NI_ISSUE;
        end
        ST_NI_ISSUE: begin
          if (ni_sel ? aw_hs : ar_hs) begin
            state <= ST_NI_WAIT;
            if (ni_arb) rr <= ~rr;
          end
        end
        ST_NI_WAIT: begin
          if (ni_sel ? b_done_i : r_done_i) state <= ST_NORMAL;
        end
        default: state <= ST_NORMAL;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_ni_access_sequencer.sv
// Scenario bench for axi_ni_access_sequencer with an issue-order scoreboard.
module tb_axi_ni_access_sequencer;
  import axi_ni_seq_pkg::*;

  localparam int unsigned AW = 64;

  typedef struct {
    logic          ch;
    logic [AW-1:0] addr;
  } exp_t;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          s_ar_valid_i, s_ar_ready_o, m_ar_valid_o, m_ar_ready_i;
  logic          s_aw_valid_i, s_aw_ready_o, m_aw_valid_o, m_aw_ready_i;
  logic [AW-1:0] s_ar_addr_i, s_aw_addr_i;
  logic          r_done_i, b_done_i, ni_busy_o, err_o;

  int   tests = 0;
  int   fails = 0;
  exp_t exp_q[$];

  axi_ni_access_sequencer #(
    .AddrWidth     (AW),
    .MaxOutstanding(7),
    .NrNiRules     (2),
    .NiAddrBase    ({64'h0, 64'h1000_0000}),
    .NiLength      ({64'h0, 64'h1000})
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .s_ar_valid_i(s_ar_valid_i),
    .s_ar_ready_o(s_ar_ready_o),
    .s_ar_addr_i (s_ar_addr_i),
    .m_ar_valid_o(m_ar_valid_o),
    .m_ar_ready_i(m_ar_ready_i),
    .s_aw_valid_i(s_aw_valid_i),
    .s_aw_ready_o(s_aw_ready_o),
    .s_aw_addr_i (s_aw_addr_i),
    .m_aw_valid_o(m_aw_valid_o),
    .m_aw_ready_i(m_aw_ready_i),
    .r_done_i    (r_done_i),
    .b_done_i    (b_done_i),
    .ni_busy_o   (ni_busy_o),
    .err_o       (err_o)
  );

  always #5 clk_i = ~clk_i;

  // Every downstream handshake must match the next expected issue.
  always @(negedge clk_i) begin
    exp_t e;
    if (!rst_i && m_ar_valid_o && m_ar_ready_i) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL sb_ar unexpected issue addr=%h", s_ar_addr_i);
      end else begin
        e = exp_q.pop_front();
        if (e.ch !== 1'b0 || e.addr !== s_ar_addr_i) begin
          fails++;
          $display("FAIL sb_ar got ch=0 addr=%h expected ch=%0d addr=%h", s_ar_addr_i, e.ch, e.addr);
        end
      end
    end
    if (!rst_i && m_aw_valid_o && m_aw_ready_i) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL sb_aw unexpected issue addr=%h", s_aw_addr_i);
      end else begin
        e = exp_q.pop_front();
        if (e.ch !== 1'b1 || e.addr !== s_aw_addr_i) begin
          fails++;
          $display("FAIL sb_aw got ch=1 addr=%h expected ch=%0d addr=%h", s_aw_addr_i, e.ch, e.addr);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push(input logic ch, input logic [AW-1:0] addr);
    exp_t e;
    e.ch = ch;
    e.addr = addr;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    cyc();
    cyc();
    rst_i = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    s_ar_valid_i = 0; s_aw_valid_i = 0; m_ar_ready_i = 0; m_aw_ready_i = 0;
    s_ar_addr_i = '0; s_aw_addr_i = '0; r_done_i = 0; b_done_i = 0;
    rst_i = 1'b1;
    cyc();
    #1;
    tests++;
    if ({m_ar_valid_o, s_ar_ready_o, m_aw_valid_o, s_aw_ready_o, ni_busy_o, err_o} !== 6'b0) begin
      fails++;
      $display("FAIL reset_outputs got %b expected 000000",
               {m_ar_valid_o, s_ar_ready_o, m_aw_valid_o, s_aw_ready_o, ni_busy_o, err_o});
    end
    tests++;
    if (dut.rd_cnt !== 3'd0 || dut.wr_cnt !== 3'd0 || dut.state !== ST_NORMAL) begin
      fails++;
      $display("FAIL reset_state got rd=%0d wr=%0d st=%0d expected 0 0 0", dut.rd_cnt, dut.wr_cnt, dut.state);
    end
    rst_i = 1'b0;
    cyc();
  endtask

  task automatic test_outstanding();
    m_ar_ready_i = 1;
    s_ar_addr_i  = 64'h8000_0000;
    s_ar_valid_i = 1;
    for (int i = 0; i < 7; i++) begin
      #1;
      tests++;
      if (!(s_ar_ready_o === 1'b1 && m_ar_valid_o === 1'b1)) begin
        fails++;
        $display("FAIL pass_ar%0d got ready=%b valid=%b expected 1 1", i, s_ar_ready_o, m_ar_valid_o);
      end
      push(1'b0, s_ar_addr_i);
      cyc();
    end
    for (int i = 0; i < 2; i++) begin
      #1;
      tests++;
      if (s_ar_ready_o !== 1'b0) begin
        fails++;
        $display("FAIL limit_hold%0d got ready=%b expected 0", i, s_ar_ready_o);
      end
      cyc();
    end
    r_done_i = 1;
    #1;
    tests++;
    if (s_ar_ready_o !== 1'b0) begin
      fails++;
      $display("FAIL limit_done_cycle got ready=%b expected 0", s_ar_ready_o);
    end
    cyc();
    r_done_i = 0;
    #1;
    tests++;
    if (s_ar_ready_o !== 1'b1) begin
      fails++;
      $display("FAIL limit_release got ready=%b expected 1", s_ar_ready_o);
    end
    push(1'b0, s_ar_addr_i);
    cyc();
    s_ar_valid_i = 0;
    #1;
    tests++;
    if (dut.rd_cnt !== 3'd7) begin
      fails++;
      $display("FAIL rd_cnt_full got %0d expected 7", dut.rd_cnt);
    end
    for (int i = 0; i < 7; i++) begin
      r_done_i = 1;
      cyc();
    end
    r_done_i = 0;
  endtask

  task automatic test_ni_drain();
    m_aw_ready_i = 1;
    s_aw_addr_i  = 64'h8000_0000;
    s_aw_valid_i = 1;
    for (int i = 0; i < 2; i++) begin
      push(1'b1, s_aw_addr_i);
      cyc();
    end
    s_aw_addr_i = 64'h1000_0004;
    #1;
    tests++;
    if (m_aw_valid_o !== 1'b0 || s_aw_ready_o !== 1'b0) begin
      fails++;
      $display("FAIL ni_detect_nogrant got valid=%b ready=%b expected 0 0", m_aw_valid_o, s_aw_ready_o);
    end
    cyc();
    tests++;
    if (ni_busy_o !== 1'b1 || dut.state !== ST_DRAIN) begin
      fails++;
      $display("FAIL drain_entry got busy=%b st=%0d expected 1 %0d", ni_busy_o, dut.state, ST_DRAIN);
    end
    s_ar_addr_i  = 64'h8000_0000;
    s_ar_valid_i = 1;
    #1;
    tests++;
    if (m_ar_valid_o !== 1'b0) begin
      fails++;
      $display("FAIL drain_blocks_ar got valid=%b expected 0", m_ar_valid_o);
    end
    s_ar_valid_i = 0;
    cyc();
    b_done_i = 1;
    cyc();
    b_done_i = 0;
    cyc();
    b_done_i = 1;
    #1;
    tests++;
    if (m_aw_valid_o !== 1'b0) begin
      fails++;
      $display("FAIL drain_last_done got valid=%b expected 0", m_aw_valid_o);
    end
    cyc();
    b_done_i = 0;
    #1;
    tests++;
    if (dut.wr_cnt !== 3'd0 || m_aw_valid_o !== 1'b0) begin
      fails++;
      $display("FAIL drain_zero_cycle got wr=%0d valid=%b expected 0 0", dut.wr_cnt, m_aw_valid_o);
    end
    push(1'b1, s_aw_addr_i);
    cyc();
    tests++;
    if (m_aw_valid_o !== 1'b1) begin
      fails++;
      $display("FAIL ni_grant got valid=%b expected 1", m_aw_valid_o);
    end
    cyc();
    s_aw_valid_i = 0;
    #1;
    tests++;
    if (ni_busy_o !== 1'b1 || dut.state !== ST_NI_WAIT) begin
      fails++;
      $display("FAIL ni_wait got busy=%b st=%0d expected 1 %0d", ni_busy_o, dut.state, ST_NI_WAIT);
    end
    cyc();
    b_done_i = 1;
    #1;
    tests++;
    if (ni_busy_o !== 1'b1) begin
      fails++;
      $display("FAIL ni_busy_done_cycle got %b expected 1", ni_busy_o);
    end
    cyc();
    b_done_i = 0;
    #1;
    tests++;
    if (ni_busy_o !== 1'b0) begin
      fails++;
      $display("FAIL ni_busy_clear got %b expected 0", ni_busy_o);
    end
  endtask

  // Acts as downstream: retires each accepted request a few cycles later.
  task automatic serve(input int budget);
    int   rcd, bcd, n;
    logic hs_ar, hs_aw;
    rcd = 0; bcd = 0; n = 0;
    while ((s_ar_valid_i || s_aw_valid_i || rcd != 0 || bcd != 0) && n < budget) begin
      r_done_i = (rcd == 1);
      b_done_i = (bcd == 1);
      #1;
      hs_ar = m_ar_valid_o & m_ar_ready_i;
      hs_aw = m_aw_valid_o & m_aw_ready_i;
      cyc();
      r_done_i = 0;
      b_done_i = 0;
      if (rcd != 0) rcd--;
      if (bcd != 0) bcd--;
      if (hs_ar) begin s_ar_valid_i = 0; rcd = 3; end
      if (hs_aw) begin s_aw_valid_i = 0; bcd = 3; end
      n++;
    end
    tests++;
    if (n >= budget) begin
      fails++;
      $display("FAIL serve_timeout got %0d cycles expected < %0d", n, budget);
    end
  endtask

  task automatic test_rr();
    do_reset();
    m_ar_ready_i = 1; m_aw_ready_i = 1;
    s_ar_addr_i = 64'h1000_0000; s_aw_addr_i = 64'h1000_0008;
    push(1'b0, s_ar_addr_i);
    push(1'b1, s_aw_addr_i);
    s_ar_valid_i = 1; s_aw_valid_i = 1;
    serve(60);
    push(1'b1, s_aw_addr_i);
    push(1'b0, s_ar_addr_i);
    s_ar_valid_i = 1; s_aw_valid_i = 1;
    serve(60);
  endtask

  task automatic test_back_to_back();
    m_ar_ready_i = 1;
    s_ar_addr_i  = 64'h8000_0040;
    s_ar_valid_i = 1;
    for (int i = 0; i < 3; i++) begin
      push(1'b0, s_ar_addr_i);
      cyc();
    end
    r_done_i = 1;
    push(1'b0, s_ar_addr_i);
    cyc();
    r_done_i = 0;
    s_ar_valid_i = 0;
    #1;
    tests++;
    if (dut.rd_cnt !== 3'd3) begin
      fails++;
      $display("FAIL simul_inc_dec got rd=%0d expected 3", dut.rd_cnt);
    end
    for (int i = 0; i < 3; i++) begin
      r_done_i = 1;
      cyc();
    end
    r_done_i = 0;
  endtask

  task automatic test_err();
    #1;
    tests++;
    if (err_o !== 1'b0 || dut.wr_cnt !== 3'd0) begin
      fails++;
      $display("FAIL err_pre got err=%b wr=%0d expected 0 0", err_o, dut.wr_cnt);
    end
    b_done_i = 1;
    cyc();
    b_done_i = 0;
    #1;
    tests++;
    if (err_o !== 1'b1 || dut.wr_cnt !== 3'd0) begin
      fails++;
      $display("FAIL err_set got err=%b wr=%0d expected 1 0", err_o, dut.wr_cnt);
    end
    repeat (3) cyc();
    tests++;
    if (err_o !== 1'b1) begin
      fails++;
      $display("FAIL err_sticky got %b expected 1", err_o);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    m_ar_ready_i = 1;
    s_ar_addr_i  = 64'h1000_0000;
    s_ar_valid_i = 1;
    push(1'b0, s_ar_addr_i);
    n = 0;
    #1;
    while (!m_ar_valid_o && n < 10) begin
      cyc();
      n++;
    end
    tests++;
    if (n >= 10) begin
      fails++;
      $display("FAIL rst_mid_issue_timeout got %0d cycles expected < 10", n);
    end
    cyc();
    s_ar_valid_i = 0;
    #1;
    tests++;
    if (dut.state !== ST_NI_WAIT || ni_busy_o !== 1'b1) begin
      fails++;
      $display("FAIL rst_mid_wait got st=%0d busy=%b expected %0d 1", dut.state, ni_busy_o, ST_NI_WAIT);
    end
    rst_i = 1;
    #1;
    tests++;
    if (dut.state !== ST_NORMAL || dut.rd_cnt !== 3'd0 || ni_busy_o !== 1'b0 || err_o !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid_async got st=%0d rd=%0d busy=%b err=%b expected 0 0 0 0",
               dut.state, dut.rd_cnt, ni_busy_o, err_o);
    end
    cyc();
    rst_i = 0;
    s_ar_addr_i  = 64'h8000_0100;
    s_ar_valid_i = 1;
    #1;
    tests++;
    if (m_ar_valid_o !== 1'b1) begin
      fails++;
      $display("FAIL rst_mid_pass got valid=%b expected 1", m_ar_valid_o);
    end
    push(1'b0, s_ar_addr_i);
    cyc();
    s_ar_valid_i = 0;
    cyc();
  endtask

  initial begin
    test_reset();
    test_outstanding();
    test_ni_drain();
    test_rr();
    test_back_to_back();
    test_err();
    test_reset_mid();
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL sb_leftover got %0d pending expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
